// File: rtl/direction_input_if.sv
// Button inputs and move-command outputs between the board buttons and the
// direction encoder.
interface direction_input_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic [2:0]  dir;
  logic        busy;
  logic [15:0] moves;

  modport master (
    output btn_up, btn_down, btn_left, btn_right,
    input  dir, busy, moves
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right,
    output dir, busy, moves
  );
endinterface

// File: rtl/direction_input.sv
// Four-button direction encoder: per-button sync + debounce + press detect,
// then a fixed-priority IDLE/EMIT/LOCKOUT FSM issuing one-cycle move codes.
module direction_input_lane #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          prev_q;
  logic          press_q;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d = '0;
      deb_d = ~deb_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      // rising edge only; releases never produce an event
      press_q <= deb_q & ~prev_q;
    end
  end

  assign press_o = press_q;
endmodule

module direction_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 64
) (
  input  logic clk,
  input  logic rst,
  direction_input_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int LW        = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0] NO_MOVE = 3'd4;

  typedef enum logic [1:0] {IDLE, EMIT, LOCKOUT} state_e;

  logic [NUM_LANES-1:0] btn;
  logic [NUM_LANES-1:0] press;

  state_e        state_q, state_d;
  logic [LW-1:0] lk_q, lk_d;
  logic [2:0]    dir_q, dir_d;
  logic          busy_q, busy_d;
  logic [15:0]   moves_q, moves_d;
  logic [2:0]    win;

  // lane index doubles as the move code: 0=up 1=down 2=left 3=right
  assign btn = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    direction_input_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn[g]),
      .press_o (press[g])
    );
  end

  always_comb begin
    win = 3'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (press[i]) win = 3'(i);
  end

  // outputs are registered from the next state so dir/busy line up with it
  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    dir_d   = NO_MOVE;
    busy_d  = 1'b0;
    moves_d = moves_q;
    case (state_q)
      IDLE: begin
        if (|press) begin
          state_d = EMIT;
          dir_d   = win;
          busy_d  = 1'b1;
          moves_d = (moves_q == 16'hFFFF) ? moves_q : moves_q + 16'd1;
        end
      end
      EMIT: begin
        state_d = LOCKOUT;
        lk_d    = '0;
        busy_d  = 1'b1;
      end
      LOCKOUT: begin
        if (lk_q == LW'(LOCKOUT_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          lk_d   = lk_q + LW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lk_q    <= '0;
      dir_q   <= NO_MOVE;
      busy_q  <= 1'b0;
      moves_q <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      moves_q <= moves_d;
    end
  end

  assign bus.dir   = dir_q;
  assign bus.busy  = busy_q;
  assign bus.moves = moves_q;
endmodule

// File: doc/direction_input.md
DIRECTION_INPUT -- requirements
Module: direction_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a button level change (min 2).
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 64, cycles after an emitted move during which new presses are discarded (min 1; > 42-cycle move sequence of the downstream game controller).
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 btn_up  input  1  raw asynchronous push-button, active-high.
REQ-006 btn_down  input  1  raw asynchronous push-button, active-high.
REQ-007 btn_left  input  1  raw asynchronous push-button, active-high.
REQ-008 btn_right  input  1  raw asynchronous push-button, active-high.
REQ-009 dir  output  3  move command to game controller: 0=up, 1=down, 2=left, 3=right, 4=no move; registered.
REQ-010 busy  output  1  high while in EMIT or LOCKOUT; registered.
REQ-011 moves  output  16  count of emitted moves, saturating at 16'hFFFF; registered.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each button SHALL have its own debounce counter (width ceil(log2(DEBOUNCE_CYCLES+1))) and debounced level; counter clears whenever synchronized level equals debounced level, else increments.
REQ-014 Debounced level SHALL toggle on the cycle the counter reaches DEBOUNCE_CYCLES-1 while mismatch persists; counter clears that cycle; any mismatch gap shorter than DEBOUNCE_CYCLES SHALL NOT change the debounced level.
REQ-015 A press event SHALL be the registered rising edge of a debounced level (one cycle wide); release edges SHALL generate no event.
REQ-016 Simultaneous press events SHALL be arbitrated by fixed priority up > down > left > right; losers discarded, not queued.
REQ-017 FSM states: IDLE, EMIT, LOCKOUT; reset state IDLE.
REQ-018 IDLE: dir=4, busy=0; on any press event go to EMIT, latch winning code.
REQ-019 EMIT: lasts exactly one cycle, dir=latched code, busy=1, moves increments (saturating); then LOCKOUT with lockout counter cleared.
REQ-020 LOCKOUT: dir=4, busy=1; all press events discarded; after exactly LOCKOUT_CYCLES cycles return to IDLE.
REQ-021 A button held continuously SHALL produce exactly one move; another move requires a debounced release then press.
REQ-022 Press event arriving in the same cycle FSM returns to IDLE SHALL be discarded; only events seen while in IDLE are accepted.
REQ-023 Latency: raw level held high from clock edge N SHALL give dir valid during the cycle following edge N+DEBOUNCE_CYCLES+3 when FSM is IDLE.
REQ-024 dir SHALL never hold a value 0-3 for more than one consecutive cycle.

Reset
REQ-025 rst=0 SHALL asynchronously force: dir=4, busy=0, moves=0, FSM IDLE, synchronizers, debounced levels, debounce and lockout counters all 0.
REQ-026 Reset asserted mid-EMIT or mid-LOCKOUT SHALL abort the move; no dir pulse after reset release until a fresh debounced press.
REQ-027 A button already held at reset release SHALL produce one move after debounce (debounced level starts 0).

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
REQ-028 btn_left held high from edge 10 -> dir=2 for exactly one cycle following edge 17, moves=1, busy high 9 cycles, then dir=4, busy=0.
REQ-029 btn_up glitch high 3 cycles then low -> dir stays 4, moves stays 0.
REQ-030 btn_down and btn_right rising on same edge, held -> single dir=1 pulse, moves=1, no dir=3 ever.
REQ-031 btn_up pressed, released, re-pressed during LOCKOUT -> only one dir=0 pulse; re-press after LOCKOUT ends -> second dir=0 pulse, moves=2.
REQ-032 rst=0 asserted mid-LOCKOUT with btn_right held -> immediately dir=4, busy=0, moves=0; after release of rst, btn_right still held -> one dir=3 pulse after debounce.
REQ-033 Force moves=16'hFFFF then one press -> dir pulse emitted, moves remains 16'hFFFF.
